// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: grants the fetch or data port onto one fixed-wait memory bus. Rev 1.0
// Optional macro ARB_FAIR_EN adds fetch-starvation protection bounded by FAIR_LIMIT.
`default_nettype none

module mem_bus_arbiter #(
  parameter int SRAM_WAIT = 2,
  parameter int SLOW_WAIT = 6
`ifdef ARB_FAIR_EN
  ,
  parameter int FAIR_LIMIT = 4
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_hit,
  input  logic [3:0]  i_ce,
  output logic        i_ack,
  output logic        i_miss,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_sel,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_hit,
  input  logic [3:0]  d_ce,
  output logic        d_ack,
  output logic        d_miss,
  output logic [31:0] d_rdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [3:0]  bus_ce,
  input  logic [31:0] bus_rdata,
  output logic        stall_req
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] SRAM_CNT = 4'(SRAM_WAIT);
  localparam logic [3:0] SLOW_CNT = 4'(SLOW_WAIT);

  state_t     state;
  state_t     state_next;
  logic [3:0] wait_cnt;
  logic       gnt_data;
  logic       pick_d;
  logic       pick_i;
  logic       force_fetch;
  logic       sel_hit;
  logic       sel_ok;
  logic [3:0] sel_ce;

`ifdef ARB_FAIR_EN
  localparam logic [3:0] FAIR_CNT_MAX = 4'(FAIR_LIMIT);
  logic [3:0] fair_cnt;

  assign force_fetch = (fair_cnt >= FAIR_CNT_MAX) && i_req && d_req;

  // Counts data grants that overtook a waiting fetch; saturates rather than wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fair_cnt <= '0;
    end else if (state == IDLE) begin
      if (!i_req || pick_i) begin
        fair_cnt <= '0;
      end else if (pick_d && (fair_cnt != 4'hF)) begin
        fair_cnt <= fair_cnt + 4'd1;
      end
    end
  end
`else
  assign force_fetch = 1'b0;
`endif

  assign stall_req = (i_req & ~i_ack) | (d_req & ~d_ack);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    pick_d     = d_req & ~force_fetch;
    pick_i     = i_req & ~pick_d;
    sel_ce     = pick_d ? d_ce  : i_ce;
    sel_hit    = pick_d ? d_hit : i_hit;
    sel_ok     = sel_hit & $onehot(sel_ce);
    state_next = state;
    case (state)
      IDLE:    if (pick_d | pick_i) state_next = sel_ok ? ACCESS : DONE;
      ACCESS:  if (wait_cnt == 4'd1) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= '0;
      gnt_data  <= 1'b0;
      bus_ce    <= '0;
      bus_we    <= 1'b0;
      bus_sel   <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_miss    <= 1'b0;
      d_miss    <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_d | pick_i) begin
            gnt_data <= pick_d;
            if (pick_d) d_miss <= ~sel_ok;
            else        i_miss <= ~sel_ok;
            if (sel_ok) begin
              bus_ce    <= sel_ce;
              bus_addr  <= pick_d ? d_addr : i_addr;
              bus_we    <= pick_d & d_we;
              bus_sel   <= pick_d ? d_sel : 4'hF;
              bus_wdata <= pick_d ? d_wdata : 32'h0;
              wait_cnt  <= sel_ce[0] ? SRAM_CNT : SLOW_CNT;
            end else if (pick_d) begin
              d_ack   <= 1'b1;
              d_rdata <= '0;
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= '0;
            end
          end
        end
        ACCESS: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            bus_ce  <= '0;
            bus_we  <= 1'b0;
            bus_sel <= '0;
            if (gnt_data) begin
              d_ack   <= 1'b1;
              d_rdata <= bus_we ? 32'h0 : bus_rdata;
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= bus_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: vector table, corner-case sequences and randomized traffic against
// a transaction-level schedule model of mem_bus_arbiter.
`default_nettype none

module tb_mem_bus_arbiter;

  localparam int SRAM_W   = 2;
  localparam int SLOW_W   = 6;
  localparam int FAIR_LIM = 4;
`ifdef ARB_FAIR_EN
  localparam bit FAIR_ON = 1'b1;
`else
  localparam bit FAIR_ON = 1'b0;
`endif
  localparam int NC = 160;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0, i_hit = 1'b0;
  logic [31:0] i_addr = '0;
  logic [3:0]  i_ce = '0;
  logic        i_ack, i_miss;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0, d_we = 1'b0, d_hit = 1'b0;
  logic [3:0]  d_sel = '0, d_ce = '0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_ack, d_miss;
  logic [31:0] d_rdata;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_we;
  logic [3:0]  bus_sel, bus_ce;
  logic [31:0] bus_rdata = '0;
  logic        stall_req;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.SRAM_WAIT(SRAM_W), .SLOW_WAIT(SLOW_W)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_hit(i_hit), .i_ce(i_ce),
    .i_ack(i_ack), .i_miss(i_miss), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_hit(d_hit), .d_ce(d_ce), .d_ack(d_ack), .d_miss(d_miss), .d_rdata(d_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_sel(bus_sel),
    .bus_ce(bus_ce), .bus_rdata(bus_rdata), .stall_req(stall_req)
  );

  typedef struct {
    logic        we;
    logic [3:0]  ce;
    logic        hit;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic        port_d;
    txn_t        tx;
    logic [31:0] rd;
    int          exp_lat;
    logic        exp_miss;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_sel;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input txn_t t, input logic req);
    d_req = req; d_we = t.we; d_ce = t.ce; d_hit = t.hit;
    d_addr = t.addr; d_sel = t.sel; d_wdata = t.wdata;
  endtask

  task automatic drive_i(input txn_t t, input logic req);
    i_req = req; i_ce = t.ce; i_hit = t.hit; i_addr = t.addr;
  endtask

  function automatic txn_t mk_txn(logic we, logic [3:0] ce, logic hit, logic [31:0] addr,
                                  logic [3:0] sel, logic [31:0] wd);
    txn_t t;
    t.we = we; t.ce = ce; t.hit = hit; t.addr = addr; t.sel = sel; t.wdata = wd;
    return t;
  endfunction

  function automatic vec_t mkv(logic pd, txn_t t, logic [31:0] rd, int lat, logic miss,
                               logic [31:0] erd);
    vec_t v;
    v.port_d = pd; v.tx = t; v.rd = rd; v.exp_lat = lat; v.exp_miss = miss;
    v.exp_rdata = erd; v.exp_sel = pd ? t.sel : 4'hF;
    return v;
  endfunction

  function automatic txn_t rand_txn(logic is_data);
    txn_t t;
    logic [3:0] bad [4];
    bad = '{4'b0000, 4'b0011, 4'b0110, 4'b1111};
    if ($urandom_range(0, 9) < 8) t.ce = 4'(1 << $urandom_range(0, 3));
    else                          t.ce = bad[$urandom_range(0, 3)];
    t.hit   = ($urandom_range(0, 9) != 0);
    t.addr  = $urandom;
    t.we    = is_data ? 1'($urandom_range(0, 1)) : 1'b0;
    t.sel   = is_data ? 4'($urandom) : 4'hF;
    t.wdata = $urandom;
    return t;
  endfunction

  // Single-request vector: measure ack latency and bus activity, then let the DUT return to IDLE.
  task automatic run_vec(input int n, input vec_t v);
    int   ack_cyc, acc, bad;
    logic ack;
    if (v.port_d) drive_d(v.tx, 1'b1);
    else          drive_i(v.tx, 1'b1);
    bus_rdata = v.rd;
    ack_cyc = 0; acc = 0; bad = 0;
    for (int c = 1; c <= 20 && ack_cyc == 0; c++) begin
      tick();
      ack = v.port_d ? d_ack : i_ack;
      if (ack) ack_cyc = c;
      else if (bus_ce != 4'b0) begin
        acc++;
        if (bus_ce !== v.tx.ce || bus_we !== v.tx.we || bus_addr !== v.tx.addr ||
            bus_sel !== v.exp_sel || bus_wdata !== (v.port_d ? v.tx.wdata : 32'h0)) bad++;
      end
    end
    chk($sformatf("vec%0d_latency", n), 32'(ack_cyc), 32'(v.exp_lat));
    chk($sformatf("vec%0d_access_cycles", n), 32'(acc), 32'(v.exp_miss ? 0 : v.exp_lat - 1));
    chk($sformatf("vec%0d_bus_fields", n), 32'(bad), 32'h0);
    chk($sformatf("vec%0d_miss", n), 32'(v.port_d ? d_miss : i_miss), 32'(v.exp_miss));
    if (!v.exp_miss)
      chk($sformatf("vec%0d_rdata", n), v.port_d ? d_rdata : i_rdata, v.exp_rdata);
    chk($sformatf("vec%0d_stall_at_ack", n), 32'(stall_req), 32'h0);
    chk($sformatf("vec%0d_bus_ce_done", n), 32'(bus_ce), 32'h0);
    if (v.port_d) d_req = 1'b0;
    else          i_req = 1'b0;
    tick();
    chk($sformatf("vec%0d_ack_pulse", n), 32'(v.port_d ? d_ack : i_ack), 32'h0);
  endtask

  // Reference schedule: which port is served when, and what the bus shows each cycle.
  logic [3:0]  e_ce   [NC];
  logic        e_we   [NC];
  logic [31:0] e_addr [NC];
  logic        e_dack [NC];
  logic        e_iack [NC];
  logic        e_miss [NC];
  int          e_cap  [NC];
  logic [31:0] hist   [NC];
  txn_t        dt [8];
  txn_t        ft [4];
  int          last_d, last_f, last_all;

  task automatic build_model(input int k, input int m);
    int   t, di, fi, fair, w, ack;
    logic pick_f, miss;
    txn_t tx;
    for (int c = 0; c < NC; c++) begin
      e_ce[c] = '0; e_we[c] = 1'b0; e_addr[c] = '0;
      e_dack[c] = 1'b0; e_iack[c] = 1'b0; e_miss[c] = 1'b0; e_cap[c] = -1;
    end
    t = 0; di = 0; fi = 0; fair = 0; last_d = -1; last_f = -1;
    while (di < k || fi < m) begin
      pick_f = (fi < m) && (di >= k || (FAIR_ON && fair >= FAIR_LIM));
      if (pick_f)      fair = 0;
      else if (fi < m) fair++;
      else             fair = 0;
      tx   = pick_f ? ft[fi] : dt[di];
      miss = !tx.hit || ($countones(tx.ce) != 1);
      w    = miss ? 0 : ((tx.ce == 4'b0001) ? SRAM_W : SLOW_W);
      for (int c = t + 1; c <= t + w; c++) begin
        e_ce[c] = tx.ce; e_we[c] = tx.we; e_addr[c] = tx.addr;
      end
      ack = t + w + 1;
      e_miss[ack] = miss;
      e_cap[ack]  = (miss || tx.we) ? -1 : ack - 1;
      if (pick_f) begin e_iack[ack] = 1'b1; last_f = ack; fi++; end
      else        begin e_dack[ack] = 1'b1; last_d = ack; di++; end
      t = ack + 1;
    end
    last_all = t - 1;
  endtask

  initial begin
    vec_t        vt [9];
    int          dcyc, icyc, werr, serr, nack, k, m, dh, fh;
    logic [5:0]  order;
    logic        exp_stall;
    logic [31:0] exp_rd;

    tick(); tick();
    chk("rst_bus_ce", 32'(bus_ce), 32'h0);
    chk("rst_bus_we", 32'(bus_we), 32'h0);
    chk("rst_bus_sel", 32'(bus_sel), 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_acks", 32'({i_ack, d_ack, i_miss, d_miss}), 32'h0);
    chk("rst_rdata", i_rdata | d_rdata, 32'h0);
    chk("rst_stall", 32'(stall_req), 32'h0);
    rst = 1'b1;
    tick();

    vt[0] = mkv(1'b0, mk_txn(1'b0, 4'b0001, 1'b1, 32'h0000_1000, 4'hF, 32'h0), 32'hDEAD_BEEF, 3, 1'b0, 32'hDEAD_BEEF);
    vt[1] = mkv(1'b0, mk_txn(1'b0, 4'b0010, 1'b1, 32'h0040_0000, 4'hF, 32'h0), 32'h1111_2222, 7, 1'b0, 32'h1111_2222);
    vt[2] = mkv(1'b1, mk_txn(1'b1, 4'b0001, 1'b1, 32'h0000_2000, 4'b0011, 32'h1234), 32'hCAFE_0000, 3, 1'b0, 32'h0);
    vt[3] = mkv(1'b1, mk_txn(1'b0, 4'b0100, 1'b1, 32'h0080_0010, 4'hF, 32'h9999), 32'hA5A5_5A5A, 7, 1'b0, 32'hA5A5_5A5A);
    vt[4] = mkv(1'b1, mk_txn(1'b0, 4'b0001, 1'b0, 32'h0000_3000, 4'hF, 32'h0), 32'h7777_7777, 1, 1'b1, 32'h0);
    vt[5] = mkv(1'b0, mk_txn(1'b0, 4'b0011, 1'b1, 32'h0000_4000, 4'hF, 32'h0), 32'h3333_3333, 1, 1'b1, 32'h0);
    vt[6] = mkv(1'b0, mk_txn(1'b0, 4'b0000, 1'b1, 32'h0000_5000, 4'hF, 32'h0), 32'h4444_4444, 1, 1'b1, 32'h0);
    vt[7] = mkv(1'b1, mk_txn(1'b1, 4'b1000, 1'b1, 32'h0100_0004, 4'b1000, 32'hFF00_0000), 32'h5555_5555, 7, 1'b0, 32'h0);
    vt[8] = mkv(1'b0, mk_txn(1'b0, 4'b0001, 1'b0, 32'h0000_6000, 4'hF, 32'h0), 32'h6666_6666, 1, 1'b1, 32'h0);
    for (int n = 0; n < 9; n++) begin
      run_vec(n, vt[n]);
      if (n == 3) chk("i_rdata_held", i_rdata, 32'h1111_2222);
    end

    // Collision: data write wins, fetch follows after the DONE/IDLE pair.
    drive_d(mk_txn(1'b1, 4'b0001, 1'b1, 32'h0000_2000, 4'b0011, 32'h1234), 1'b1);
    drive_i(mk_txn(1'b0, 4'b0001, 1'b1, 32'h0000_1000, 4'hF, 32'h0), 1'b1);
    bus_rdata = 32'h0BAD_F00D;
    #1;
    chk("coll_stall_c0", 32'(stall_req), 32'h1);
    dcyc = 0; icyc = 0; werr = 0; serr = 0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (d_ack) dcyc = c;
      if (i_ack) icyc = c;
      if ((c <= 2) != (bus_we === 1'b1)) werr++;
      if (stall_req !== (c < 7)) serr++;
      if (d_ack) d_req = 1'b0;
    end
    chk("coll_d_ack_cycle", 32'(dcyc), 32'd3);
    chk("coll_i_ack_cycle", 32'(icyc), 32'd7);
    chk("coll_bus_we_cycles", 32'(werr), 32'h0);
    chk("coll_stall", 32'(serr), 32'h0);
    chk("coll_i_rdata", i_rdata, 32'h0BAD_F00D);
    i_req = 1'b0;
    tick();

    // Reset in the first ACCESS cycle abandons the access; a held request is regranted.
    drive_i(mk_txn(1'b0, 4'b0001, 1'b1, 32'h0000_3000, 4'hF, 32'h0), 1'b1);
    bus_rdata = 32'h0000_0077;
    tick();
    chk("rst_mid_access_ce", 32'(bus_ce), 32'h1);
    rst = 1'b0;
    #1;
    chk("rst_mid_bus_ce", 32'(bus_ce), 32'h0);
    chk("rst_mid_no_ack", 32'(i_ack), 32'h0);
    tick();
    chk("rst_mid_no_ack2", 32'(i_ack), 32'h0);
    rst = 1'b1;
    icyc = 0;
    for (int c = 1; c <= 12 && icyc == 0; c++) begin
      tick();
      if (i_ack) icyc = c;
    end
    chk("rst_regrant_latency", 32'(icyc), 32'd3);
    i_req = 1'b0;
    tick();

    // Request dropped and fields changed mid-access, then a held back-to-back fetch.
    drive_i(mk_txn(1'b0, 4'b0001, 1'b1, 32'h0000_4000, 4'hF, 32'h0), 1'b1);
    bus_rdata = 32'h0000_0055;
    tick();
    drive_i(mk_txn(1'b0, 4'b0010, 1'b1, 32'hFFFF_0000, 4'hF, 32'h0), 1'b0);
    tick();
    chk("midchg_bus_addr", bus_addr, 32'h0000_4000);
    chk("midchg_bus_ce", 32'(bus_ce), 32'h1);
    tick();
    chk("midchg_ack", 32'(i_ack), 32'h1);
    chk("midchg_rdata", i_rdata, 32'h0000_0055);
    tick();
    drive_i(mk_txn(1'b0, 4'b0001, 1'b1, 32'h0000_5000, 4'hF, 32'h0), 1'b1);
    dcyc = 0; icyc = 0;
    for (int c = 1; c <= 12 && icyc == 0; c++) begin
      tick();
      if (i_ack && dcyc == 0) dcyc = c;
      else if (i_ack) icyc = c;
    end
    chk("b2b_first_ack", 32'(dcyc), 32'd3);
    chk("b2b_second_ack", 32'(icyc), 32'd7);
    i_req = 1'b0;
    tick();

    // Both ports held: strict priority starves fetch, fairness lets one through after FAIR_LIM.
    drive_d(mk_txn(1'b0, 4'b0001, 1'b1, 32'h0000_7000, 4'hF, 32'h0), 1'b1);
    drive_i(mk_txn(1'b0, 4'b0001, 1'b1, 32'h0000_8000, 4'hF, 32'h0), 1'b1);
    order = '0; nack = 0;
    for (int c = 1; c <= 80 && nack < 6; c++) begin
      tick();
      if (d_ack) nack++;
      if (i_ack) begin
        if (nack < 6) order[nack] = 1'b1;
        nack++;
      end
    end
    chk("held_ack_count", 32'(nack), 32'd6);
    chk("held_ack_order", 32'(order), FAIR_ON ? 32'h10 : 32'h0);
    d_req = 1'b0; i_req = 1'b0;
    tick(); tick();

    for (int it = 0; it < 40; it++) begin
      k = $urandom_range(0, 6);
      m = $urandom_range(0, 2);
      if (k + m == 0) m = 1;
      for (int j = 0; j < 8; j++) dt[j] = rand_txn(1'b1);
      for (int j = 0; j < 4; j++) ft[j] = rand_txn(1'b0);
      build_model(k, m);
      dh = 0; fh = 0;
      drive_d(dt[0], k > 0);
      drive_i(ft[0], m > 0);
      hist[0] = $urandom;
      bus_rdata = hist[0];
      #1;
      chk("rnd_stall_c0", 32'(stall_req), 32'h1);
      for (int c = 1; c <= last_all + 1; c++) begin
        tick();
        chk($sformatf("rnd%0d_c%0d_bus_ce", it, c), 32'(bus_ce), 32'(e_ce[c]));
        if (e_ce[c] != 4'b0) begin
          chk($sformatf("rnd%0d_c%0d_bus_we", it, c), 32'(bus_we), 32'(e_we[c]));
          chk($sformatf("rnd%0d_c%0d_bus_addr", it, c), bus_addr, e_addr[c]);
        end
        chk($sformatf("rnd%0d_c%0d_d_ack", it, c), 32'(d_ack), 32'(e_dack[c]));
        chk($sformatf("rnd%0d_c%0d_i_ack", it, c), 32'(i_ack), 32'(e_iack[c]));
        exp_rd = (e_cap[c] < 0) ? 32'h0 : hist[e_cap[c]];
        if (e_dack[c]) begin
          chk($sformatf("rnd%0d_c%0d_d_miss", it, c), 32'(d_miss), 32'(e_miss[c]));
          if (!e_miss[c]) chk($sformatf("rnd%0d_c%0d_d_rdata", it, c), d_rdata, exp_rd);
          dh++;
        end
        if (e_iack[c]) begin
          chk($sformatf("rnd%0d_c%0d_i_miss", it, c), 32'(i_miss), 32'(e_miss[c]));
          if (!e_miss[c]) chk($sformatf("rnd%0d_c%0d_i_rdata", it, c), i_rdata, exp_rd);
          fh++;
        end
        drive_d(dt[dh], dh < k);
        drive_i(ft[fh], fh < m);
        hist[c] = $urandom;
        bus_rdata = hist[c];
        #1;
        exp_stall = (c < last_d && !e_dack[c]) || (c < last_f && !e_iack[c]);
        chk($sformatf("rnd%0d_c%0d_stall", it, c), 32'(stall_req), 32'(exp_stall));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single physical memory bus (SRAM, flash, boot ROM, serial) between the instruction-fetch port and the data (MEM-stage) port.
- Each port arrives already translated by its own TLB lookup, carrying a physical address, a hit flag and a one-hot chip-select.
- The block grants one port at a time and runs a fixed-wait access sequence on the bus.
- It acknowledges the port and raises a pipeline stall while any request is outstanding.

Parameters:
- SRAM_WAIT, 2: bus cycles an SRAM access is held (1..15).
- SLOW_WAIT, 6: bus cycles a flash, ROM or serial access is held (1..15).
- FAIR_LIMIT, 4: consecutive data grants before the fetch port is forced (optional feature only).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- i_req  input  1  fetch request, held until i_ack
- i_addr  input  32  fetch physical address
- i_hit  input  1  fetch TLB hit
- i_ce  input  4  fetch chip-select one-hot {serial,rom,flash,sram}
- i_ack  output  1  fetch done, 1-cycle pulse
- i_miss  output  1  fetch refused (valid with i_ack)
- i_rdata  output  32  fetch read data (valid with i_ack)
- d_req  input  1  data request, held until d_ack
- d_we  input  1  data write
- d_sel  input  4  byte enables
- d_addr  input  32  data physical address
- d_wdata  input  32  write data
- d_hit  input  1  data TLB hit
- d_ce  input  4  data chip-select one-hot {serial,rom,flash,sram}
- d_ack  output  1  data done, 1-cycle pulse
- d_miss  output  1  data refused (valid with d_ack)
- d_rdata  output  32  data read data (valid with d_ack)
- bus_addr  output  32  bus address
- bus_wdata  output  32  bus write data
- bus_we  output  1  bus write strobe
- bus_sel  output  4  bus byte enables
- bus_ce  output  4  bus chip-select one-hot
- bus_rdata  input  32  bus read data
- stall_req  output  1  stall request to pipeline control

Behaviour:
- Reset (rst=0, asynchronous):
  - state goes to IDLE.
  - All registered outputs go to 0: bus_ce, bus_we, bus_sel, bus_addr, bus_wdata, i_ack, d_ack, i_miss, d_miss, i_rdata, d_rdata, wait counter, fairness counter.
  - An access in progress is abandoned and no ack is issued.
- States are IDLE, ACCESS, DONE. All outputs are registered except stall_req.
- IDLE:
  - If d_req=1, grant data; else if i_req=1, grant fetch; else stay in IDLE.
  - On both requests in the same cycle, data wins (older instruction).
  - If the granted port has hit=0, or its ce is not exactly one-hot, go to DONE with miss=1. No bus activity.
  - Otherwise latch addr, ce, we, sel and wdata (fetch: we=0, sel=4'hF, wdata=0).
  - Load the counter with SRAM_WAIT if ce[0], else SLOW_WAIT, and go to ACCESS.
- ACCESS:
  - bus_* are driven from the latched values and are constant for the whole state.
  - The counter decrements each cycle.
  - On the cycle the counter equals 1, capture bus_rdata into the granted port's rdata; the next state is DONE.
  - Writes: bus_we=1 for every ACCESS cycle; rdata is captured as 0.
- DONE:
  - bus_ce, bus_we and bus_sel are 0.
  - The granted port's ack=1 for exactly one cycle; miss and rdata are valid in that cycle and hold until the next grant to that port.
  - Next state is IDLE. No new grant is made in DONE.
- Latency:
  - Hit: request seen in IDLE at cycle 0 → ACCESS cycles 1..W → ack at cycle W+1.
  - Miss: ack at cycle 1.
- stall_req = (i_req & ~i_ack) | (d_req & ~d_ack), combinational.
- A requester deasserting req mid-access does not abort the access; the ack is still pulsed.
- A requester changing its fields mid-access has no effect, because the fields are latched at grant.
- Back-to-back: a request held after its ack is regranted on the following IDLE cycle.

Optional Feature:
- Macro: ARB_FAIR_EN.
- Defined:
  - A 4-bit counter counts consecutive data grants made while i_req=1.
  - When the count reaches FAIR_LIMIT and both ports request in IDLE, fetch is granted and the counter clears.
  - The counter also clears on any fetch grant or on any IDLE cycle with i_req=0.
- Undefined: strict data priority; the counter logic is absent.

Test Plan:
- Fetch SRAM read: i_req=1, i_addr=32'h0000_1000, i_hit=1, i_ce=4'b0001, bus_rdata=32'hDEADBEEF → bus_ce=0001 for cycles 1–2, i_ack with i_rdata=DEADBEEF at cycle 3, stall_req=0 at cycle 4 after i_req drops.
- Collision: i_req and d_req both rise; d_we=1, d_addr=32'h0000_2000, d_sel=4'b0011, d_wdata=32'h1234 →
  - Data served first: bus_we=1 for 2 cycles, d_ack at cycle 3.
  - Fetch granted at cycle 4, i_ack at cycle 7.
  - stall_req high throughout.
- TLB miss: d_req=1, d_hit=0 → d_ack=1 and d_miss=1 at cycle 1, bus_ce stays 0.
- Flash read: i_ce=4'b0010 with SLOW_WAIT=6 → bus_ce=0010 for cycles 1–6, i_ack at cycle 7.
- Reset mid-access: rst=0 at ACCESS cycle 1 → bus_ce=0 immediately, no ack. After release, with i_req still high, the fetch is regranted and acked 3 cycles later.
- ARB_FAIR_EN, FAIR_LIMIT=4: d_req and i_req held continuously → data acked 4 times, then a fetch ack, then data resumes.
